// File: rtl/vga_cursor_overlay.sv
// rtl/vga_cursor_overlay.sv - cursor and border renderer behind the VGA timing generator
// Two-stage pipeline; IR positions are double-buffered and only take effect at vsync.

module vga_cursor_overlay #(
    parameter int         H_OFF          = 49,
    parameter int         V_OFF          = 33,
    parameter int         SCREEN_W       = 640,
    parameter int         SCREEN_H       = 480,
    parameter int         CURSOR_SIZE    = 16,
    parameter int         TIMEOUT_FRAMES = 30,
    parameter int         BLINK_FRAMES   = 15,
    parameter logic [7:0] BG_COLOR       = 8'h00,
    parameter logic [7:0] BORDER_COLOR   = 8'hFF,
    parameter logic [7:0] CURSOR_COLOR   = 8'h1C,
    parameter logic [7:0] LOST_COLOR     = 8'hE0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       en,
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_valid,
    output logic       pos_ready,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_tick,
    output logic       stale
);

    localparam int FCW = $clog2(TIMEOUT_FRAMES + 1);
    localparam int BCW = $clog2(BLINK_FRAMES + 1);

    localparam logic [9:0]     MAX_X      = 10'(SCREEN_W - CURSOR_SIZE);
    localparam logic [9:0]     MAX_Y      = 10'(SCREEN_H - CURSOR_SIZE);
    localparam logic [9:0]     HOME_X     = 10'((SCREEN_W - CURSOR_SIZE) / 2);
    localparam logic [9:0]     HOME_Y     = 10'((SCREEN_H - CURSOR_SIZE) / 2);
    localparam logic [9:0]     H_OFF_C    = 10'(H_OFF);
    localparam logic [9:0]     V_OFF_C    = 10'(V_OFF);
    localparam logic [9:0]     LAST_X     = 10'(SCREEN_W - 1);
    localparam logic [9:0]     LAST_Y     = 10'(SCREEN_H - 1);
    localparam logic [10:0]    SIZE_C     = 11'(CURSOR_SIZE);
    localparam logic [FCW-1:0] TIMEOUT_C  = FCW'(TIMEOUT_FRAMES);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

    typedef enum logic {
        TRACKING = 1'b0,
        STALE    = 1'b1
    } stateT;

    // Strobe is not needed: every stage advances on every clock.
    logic unusedReq;
    assign unusedReq = req;

    logic       enS1;
    logic [9:0] colS1;
    logic [9:0] rowS1;
    logic       hsyncS1;
    logic       vsyncS1;
    logic       vsyncS1d;

    logic       pending;
    logic [9:0] pendX;
    logic [9:0] pendY;
    logic [9:0] curX;
    logic [9:0] curY;

    stateT          state;
    stateT          stateNext;
    logic [FCW-1:0] frameCnt;
    logic [FCW-1:0] frameCntNext;
    logic [BCW-1:0] blinkCnt;
    logic [BCW-1:0] blinkCntNext;
    logic           blinkPhase;
    logic           blinkPhaseNext;

    logic       frameEvent;
    logic       accept;
    logic       commit;
    logic [9:0] clampX;
    logic [9:0] clampY;

    assign frameEvent = vsyncS1d & ~vsyncS1;
    assign pos_ready  = ~pending;
    assign accept     = pos_valid & ~pending;
    assign commit     = frameEvent & pending;
    assign clampX     = (pos_x > MAX_X) ? MAX_X : pos_x;
    assign clampY     = (pos_y > MAX_Y) ? MAX_Y : pos_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enS1     <= 1'b0;
            colS1    <= '0;
            rowS1    <= '0;
            hsyncS1  <= 1'b1;
            vsyncS1  <= 1'b1;
            vsyncS1d <= 1'b1;
        end else begin
            enS1     <= en;
            colS1    <= col;
            rowS1    <= row;
            hsyncS1  <= hsync;
            vsyncS1  <= vsync;
            vsyncS1d <= vsyncS1;
        end
    end

    // Accept and commit are mutually exclusive because accept needs pending empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            pendX   <= '0;
            pendY   <= '0;
            curX    <= HOME_X;
            curY    <= HOME_Y;
        end else begin
            if (commit) begin
                curX    <= pendX;
                curY    <= pendY;
                pending <= 1'b0;
            end
            if (accept) begin
                pendX   <= clampX;
                pendY   <= clampY;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        stateNext      = state;
        frameCntNext   = frameCnt;
        blinkCntNext   = blinkCnt;
        blinkPhaseNext = blinkPhase;
        if (frameEvent) begin
            if (pending) begin
                stateNext    = TRACKING;
                frameCntNext = '0;
            end else begin
                if (frameCnt != TIMEOUT_C) begin
                    frameCntNext = frameCnt + 1'b1;
                end
                if (state == TRACKING) begin
                    if (frameCntNext == TIMEOUT_C) begin
                        stateNext      = STALE;
                        blinkCntNext   = '0;
                        blinkPhaseNext = 1'b1;
                    end
                end else if (blinkCnt == BLINK_LAST) begin
                    blinkCntNext   = '0;
                    blinkPhaseNext = ~blinkPhase;
                end else begin
                    blinkCntNext = blinkCnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STALE;
            frameCnt   <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
            stale      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= stateNext;
            frameCnt   <= frameCntNext;
            blinkCnt   <= blinkCntNext;
            blinkPhase <= blinkPhaseNext;
            stale      <= (stateNext == STALE);
            frame_tick <= frameEvent;
        end
    end

    logic [9:0]  scrX;
    logic [9:0]  scrY;
    logic [10:0] endX;
    logic [10:0] endY;
    logic        cursorHit;
    logic        borderHit;
    logic [7:0]  cursorColor;
    logic [7:0]  pixel;

    assign scrX = colS1 - H_OFF_C;
    assign scrY = rowS1 - V_OFF_C;
    assign endX = {1'b0, curX} + SIZE_C;
    assign endY = {1'b0, curY} + SIZE_C;

    // Widened compares so a cursor near the right/bottom edge cannot wrap.
    assign cursorHit = ({1'b0, scrX} >= {1'b0, curX}) && ({1'b0, scrX} < endX) &&
                       ({1'b0, scrY} >= {1'b0, curY}) && ({1'b0, scrY} < endY);
    assign borderHit = (scrX == 10'd0) || (scrX == LAST_X) ||
                       (scrY == 10'd0) || (scrY == LAST_Y);

    assign cursorColor = (state == TRACKING) ? CURSOR_COLOR :
                         (blinkPhase ? LOST_COLOR : BG_COLOR);

    always_comb begin
        pixel = 8'h00;
        if (enS1) begin
            if (cursorHit) begin
                pixel = cursorColor;
            end else if (borderHit) begin
                pixel = BORDER_COLOR;
            end else begin
                pixel = BG_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            red     <= pixel[7:5];
            green   <= pixel[4:2];
            blue    <= pixel[1:0];
            hsync_o <= hsyncS1;
            vsync_o <= vsyncS1;
        end
    end

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// tb/tb_vga_cursor_overlay.sv - scoreboard bench for vga_cursor_overlay

module tb_vga_cursor_overlay;

    localparam int H_OFF = 49;
    localparam int V_OFF = 33;
    localparam logic [7:0] BG = 8'h00;
    localparam logic [7:0] BORDER = 8'hFF;
    localparam logic [7:0] TRACK = 8'h1C;
    localparam logic [7:0] LOST = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       en;
    logic [9:0] col;
    logic [9:0] row;
    logic       hsync;
    logic       vsync;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_valid;
    logic       pos_ready;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       hsync_o;
    logic       vsync_o;
    logic       frame_tick;
    logic       stale;

    always #5 clk = ~clk;

    vga_cursor_overlay dut (
        .clk(clk), .rst_n(rst_n), .req(req), .en(en), .col(col), .row(row),
        .hsync(hsync), .vsync(vsync), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .red(red), .green(green),
        .blue(blue), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_tick(frame_tick), .stale(stale)
    );

    typedef struct {
        logic       en;
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       pv;
    } drvT;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state, updated once per clock edge.
    int  mCx, mCy, mPx, mPy, mFrm, mBlk;
    bit  mPend, mStale, mPhase, v2, v3;
    int  qx[$];
    int  qy[$];
    int  injX[$];
    int  injY[$];
    logic [9:0] expQ[$];
    drvT cur;
    bit  chkOn = 1'b0;
    int  cyc = 0;

    int fullX[$] = '{0, 1, 99, 100, 115, 116, 200, 300, 311, 312, 327, 328, 400, 623, 624, 638, 639};
    int fullY[$] = '{0, 49, 50, 65, 66, 100, 200, 231, 232, 247, 248, 300, 463, 464, 478, 479};
    int quickX[$] = '{100, 312};
    int quickY[$] = '{50, 232};

    function automatic logic [7:0] expPixel(input drvT d);
        int sx, sy;
        if (!d.en) return 8'h00;
        sx = (int'(d.col) - H_OFF + 1024) % 1024;
        sy = (int'(d.row) - V_OFF + 1024) % 1024;
        if (sx >= mCx && sx < mCx + 16 && sy >= mCy && sy < mCy + 16) begin
            if (!mStale) return TRACK;
            return mPhase ? LOST : BG;
        end
        if (sx == 0 || sx == 639 || sy == 0 || sy == 479) return BORDER;
        return BG;
    endfunction

    task automatic modelInit();
        mCx = 312; mCy = 232; mPend = 0; mStale = 1;
        mFrm = 0; mBlk = 0; mPhase = 1; v2 = 1; v3 = 1;
        cur.en = 0; cur.col = 0; cur.row = 0; cur.hs = 1; cur.vs = 1; cur.pv = 0;
    endtask

    task automatic modelEdge(output bit evt);
        bit wasPend;
        evt = v3 && !v2;
        wasPend = mPend;
        if (evt) begin
            if (wasPend) begin
                mCx = mPx; mCy = mPy; mPend = 0; mStale = 0; mFrm = 0;
            end else begin
                if (mFrm < 30) mFrm++;
                if (!mStale) begin
                    if (mFrm == 30) begin
                        mStale = 1; mBlk = 0; mPhase = 1;
                    end
                end else begin
                    mBlk++;
                    if (mBlk == 15) begin
                        mBlk = 0; mPhase = !mPhase;
                    end
                end
            end
        end
        if (cur.pv && !wasPend) begin
            mPx = (qx[0] > 624) ? 624 : qx[0];
            mPy = (qy[0] > 464) ? 464 : qy[0];
            void'(qx.pop_front());
            void'(qy.pop_front());
            mPend = 1;
        end
        v3 = v2;
        v2 = cur.vs;
    endtask

    task automatic step(input bit e, input int c, input int r, input bit h, input bit v);
        bit evt;
        @(posedge clk);
        #1;
        modelEdge(evt);
        if (chkOn) check("ctl", {frame_tick, stale, pos_ready}, {evt, mStale, !mPend});
        expQ.push_back({expPixel(cur), cur.hs, cur.vs});
        cur.en = e; cur.col = 10'(c); cur.row = 10'(r); cur.hs = h; cur.vs = v;
        cur.pv = (qx.size() != 0);
        en = cur.en; col = cur.col; row = cur.row; hsync = cur.hs; vsync = cur.vs;
        pos_valid = cur.pv;
        pos_x = cur.pv ? 10'(qx[0]) : 10'd0;
        pos_y = cur.pv ? 10'(qy[0]) : 10'd0;
        req = (cyc % 4 == 0);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (chkOn && expQ.size() >= 2) begin
            check("pix", {red, green, blue, hsync_o, vsync_o}, expQ.pop_front());
        end
    end

    task automatic doLine(input int y, input int xs[$]);
        foreach (xs[j]) step(1, xs[j] + H_OFF, y + V_OFF, 1, 1);
        step(0, H_OFF + 312, y + V_OFF, 0, 1);
        step(0, H_OFF + 312, y + V_OFF, 0, 1);
        step(0, H_OFF + 312, y + V_OFF, 1, 1);
    endtask

    task automatic doFrame(input bit full);
        int ys[$];
        int xs[$];
        ys = full ? fullY : quickY;
        xs = full ? fullX : quickX;
        repeat (3) step(0, 0, 0, 1, 0);
        repeat (2) step(0, H_OFF + 312, V_OFF + 232, 1, 1);
        foreach (ys[i]) begin
            if (i == ys.size() / 2) begin
                foreach (injX[k]) begin
                    qx.push_back(injX[k]);
                    qy.push_back(injY[k]);
                end
                injX.delete();
                injY.delete();
            end
            doLine(ys[i], xs);
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [7:0] expc);
        step(1, x + H_OFF, y + V_OFF, 1, 1);
        step(0, 0, y + V_OFF, 1, 1);
        step(0, 0, y + V_OFF, 1, 1);
        check(tag, {red, green, blue}, expc);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rgb"}, {red, green, blue}, 8'h00);
        check({tag, "_syncs"}, {hsync_o, vsync_o}, 2'b11);
        check({tag, "_tick"}, frame_tick, 1'b0);
        check({tag, "_ready"}, pos_ready, 1'b1);
        check({tag, "_stale"}, stale, 1'b1);
    endtask

    task automatic driveIdle();
        en = 0; col = 0; row = 0; hsync = 1; vsync = 1;
        pos_valid = 0; pos_x = 0; pos_y = 0; req = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        driveIdle();
        modelInit();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        chkOn = 1'b1;

        doFrame(1);
        doFrame(1);
        probe("lost_on", 312, 232, LOST);
        probe("left_of_cursor", 311, 232, BG);
        probe("border_left", 0, 10, BORDER);
        check("stale_init", stale, 1'b1);
        repeat (14) doFrame(0);
        doFrame(1);
        probe("lost_off", 312, 232, BG);

        injX = '{100}; injY = '{50};
        doFrame(1);
        check("ready_held", pos_ready, 1'b0);
        probe("old_pos", 100, 50, BG);
        doFrame(1);
        check("stale_tracking", stale, 1'b0);
        probe("cursor_100_50", 100, 50, TRACK);
        probe("cursor_99_50", 99, 50, BG);
        probe("cursor_116_50", 116, 50, BG);
        probe("cursor_115_65", 115, 65, TRACK);

        injX = '{639}; injY = '{479};
        doFrame(1);
        doFrame(1);
        probe("clamp_corner", 639, 479, TRACK);
        probe("clamp_origin", 624, 464, TRACK);
        probe("clamp_outside", 623, 464, BG);
        probe("border_top_right", 639, 0, BORDER);

        injX = '{200, 300}; injY = '{100, 200};
        doFrame(1);
        check("b2b_ready0", pos_ready, 1'b0);
        doFrame(1);
        probe("b2b_first", 200, 100, TRACK);
        check("b2b_second_held", pos_ready, 1'b0);
        doFrame(1);
        probe("b2b_second", 300, 200, TRACK);
        probe("b2b_first_gone", 200, 100, BG);
        check("b2b_ready1", pos_ready, 1'b1);

        repeat (29) doFrame(0);
        check("timeout_29", stale, 1'b0);
        doFrame(0);
        check("timeout_30", stale, 1'b1);
        probe("timeout_colour", 300, 200, LOST);
        injX = '{400}; injY = '{300};
        doFrame(0);
        doFrame(1);
        check("recovered", stale, 1'b0);
        probe("recovered_colour", 400, 300, TRACK);

        injX = '{10}; injY = '{10};
        doFrame(0);
        step(1, H_OFF + 400, V_OFF + 300, 1, 1);
        step(1, H_OFF + 401, V_OFF + 300, 1, 1);
        check("pend_before_rst", pos_ready, 1'b0);
        #2;
        chkOn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midline_reset");
        driveIdle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelInit();
        expQ.delete();
        chkOn = 1'b1;
        doFrame(1);
        probe("home_after_rst", 312, 232, LOST);
        probe("no_pending_commit", 10, 10, BG);
        check("stale_after_rst", stale, 1'b1);

        repeat (4) step(0, 0, 0, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/vga_cursor_overlay.md
Name: vga_cursor_overlay

Overview:
- Pixel renderer directly downstream of the VGA signal generator. Consumes its pixel strobe, active-video enable, col/row counters and syncs.
- Draws a solid square cursor at the latest IR-derived position, plus a 1-pixel screen border, and outputs 8-bit RGB with re-aligned syncs.
- Position updates arrive via a valid/ready handshake and are applied only at vsync, so frames never tear.
- Tracks position staleness and shows a blinking "lost" colour when IR updates stop.

Parameters:
- H_OFF, 49: col value of the first visible pixel (screen x = col - H_OFF).
- V_OFF, 33: row value of the first visible line (screen y = row - V_OFF).
- SCREEN_W, 640: visible width in pixels.
- SCREEN_H, 480: visible height in pixels.
- CURSOR_SIZE, 16: cursor square edge, pixels.
- TIMEOUT_FRAMES, 30: frames without a committed update before the block enters STALE.
- BLINK_FRAMES, 15: frames per blink half-period in STALE.
- BG_COLOR, 8'h00: background RGB332.
- BORDER_COLOR, 8'hFF: border RGB332.
- CURSOR_COLOR, 8'h1C: tracking cursor colour (green).
- LOST_COLOR, 8'hE0: stale cursor colour (red).

Ports:
- clk  in  1  system clock (same clock as the generator)
- rst_n  in  1  asynchronous active-low reset
- req  in  1  pixel strobe, high 1 of 4 clocks
- en  in  1  active-video enable
- col  in  10  horizontal counter
- row  in  10  vertical counter
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- pos_x  in  10  new cursor x (screen coordinates)
- pos_y  in  10  new cursor y
- pos_valid  in  1  pos_x/pos_y valid
- pos_ready  out  1  block can accept a position
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- hsync_o  out  1  hsync delayed to match RGB
- vsync_o  out  1  vsync delayed to match RGB
- frame_tick  out  1  one-clock pulse at each vsync falling edge
- stale  out  1  high in STALE state

Behaviour:
- Reset (async, rst_n=0):
  - red/green/blue=0, hsync_o=vsync_o=1, frame_tick=0.
  - pending empty, so pos_ready=1.
  - Committed position = ((SCREEN_W-CURSOR_SIZE)/2, (SCREEN_H-CURSOR_SIZE)/2).
  - state=STALE, stale=1, frame and blink counters=0.
  - Reset mid-frame discards any pending position.
- Pipeline, fixed 2-clock latency for every input-to-output path, independent of req:
  - S1: register en, col, row, hsync, vsync.
  - S2: compute x=col-H_OFF and y=row-V_OFF (10-bit wrap); evaluate the hit tests; register RGB, hsync_o and vsync_o.
- Pixel priority:
  - If !en_s1, output RGB=0.
  - Else cursor, when cx<=x<cx+CURSOR_SIZE and cy<=y<cy+CURSOR_SIZE (compare at 11 bits, no wrap).
  - Else border, when x==0, x==SCREEN_W-1, y==0 or y==SCREEN_H-1.
  - Else BG_COLOR.
- Cursor colour: CURSOR_COLOR in TRACKING. In STALE, LOST_COLOR when blink phase=1, BG_COLOR when blink phase=0.
- Handshake:
  - pos_ready = !pending.
  - Transfer occurs when pos_valid && pos_ready.
  - Accepted values are clamped to x<=SCREEN_W-CURSOR_SIZE and y<=SCREEN_H-CURSOR_SIZE, then stored in the single-entry pending register.
  - A producer holding pos_valid while pos_ready=0 stalls; the block never drops accepted data.
- Frame event: vsync_s1 transitions 1->0, giving frame_tick=1 for exactly one clock.
- On a frame event with pending full: committed position <= pending, pending cleared, state <= TRACKING, frame counter <= 0.
- Simultaneous frame event and accept with pending empty: the incoming value goes into pending and commits at the next frame event.
- On a frame event with no commit: the frame counter saturates at TIMEOUT_FRAMES. Reaching TIMEOUT_FRAMES sets state <= STALE.
- Blink: in STALE, the blink counter counts frame events and toggles the blink phase every BLINK_FRAMES. It resets to 0, phase=1, on entry to STALE.
- stale output = (state==STALE), registered.

Test Plan:
- Reset, then run generator-style stimulus for 2 frames with no pos_valid -> cursor drawn at (312,232) in LOST_COLOR/BG alternating per 15 frames; stale=1; RGB=0 whenever en=0; hsync_o/vsync_o equal the inputs delayed exactly 2 clocks.
- Send pos (100,50) mid-frame -> pos_ready drops for one transfer; cursor stays at the old position for the rest of that frame; from the next frame, pixel (100,50) is 8'h1C, (99,50) and (116,50) are BG, stale=0.
- Send pos (639,479) -> clamped; cursor covers x 624..639, y 464..479; cursor overrides the border at (639,479).
- Send two positions back-to-back within one frame -> second held (pos_ready=0) until the next vsync fall; first commits, then second commits one frame later.
- Commit once, then 30 frame events with no update -> stale rises on the 30th frame_tick; a new commit returns TRACKING with colour 8'h1C.
- Assert rst_n low mid-line with pending full -> outputs immediately take reset values, pos_ready=1, cursor returns to centre.
